// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Round-robin arbiter that owns the single BlockRam port and
//            serialises one read or write at a time among NUM_REQ requesters.
//            It is the only driver of the BlockRam address/data/enable pins.
// Ports    :
//   clock            in   1                    single clock, posedge
//   reset            in   1                    asynchronous, active-low
//   req_valid        in   NUM_REQ              level request, held until ready
//   req_write        in   NUM_REQ              1 = write, 0 = read
//   req_addr         in   NUM_REQ*MADDR_WIDTH  flattened, slice i = requester i
//   req_wdata        in   NUM_REQ*MDATA_WIDTH  flattened write data
//   req_ready        out  NUM_REQ              one-cycle completion pulse
//   req_rdata        out  MDATA_WIDTH          read data, valid with req_ready
//   grant            out  NUM_REQ              one-hot port owner, 0 when idle
//   timeout_err      out  1                    sticky, cleared only by reset
//   mem_addr         out  MADDR_WIDTH          to BlockRam
//   mem_write_data   out  MDATA_WIDTH          to BlockRam
//   mem_read_enable  out  1                    to BlockRam
//   mem_write_enable out  1                    to BlockRam
//   mem_read_ready   in   1                    from BlockRam
//   mem_write_ready  in   1                    from BlockRam
//   mem_read_data    in   MDATA_WIDTH          from BlockRam
// Revision : 1.0  initial release
// ============================================================================

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

module memory_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [MDATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           timeout_err,
  output logic [MADDR_WIDTH-1:0]         mem_addr,
  output logic [MDATA_WIDTH-1:0]         mem_write_data,
  output logic                           mem_read_enable,
  output logic                           mem_write_enable,
  input  logic                           mem_read_ready,
  input  logic                           mem_write_ready,
  input  logic [MDATA_WIDTH-1:0]         mem_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   terr_q, terr_d;

  // Round-robin pick: lowest valid index at or above the pointer, otherwise
  // the lowest valid index overall (the wrap-around case). The loop runs
  // downwards so the last hit recorded is the lowest index.
  logic                   found_hi;
  logic [IDX_W-1:0]       hi_idx, lo_idx, pick_idx;
  logic [MADDR_WIDTH-1:0] sel_addr;
  logic [MDATA_WIDTH-1:0] sel_wdata;
  logic                   sel_write;

  always_comb begin
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_idx   = IDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick_idx = found_hi ? hi_idx : lo_idx;

    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_addr  = req_addr[i*MADDR_WIDTH +: MADDR_WIDTH];
        sel_wdata = req_wdata[i*MDATA_WIDTH +: MDATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Only the ready matching the latched operation completes an access.
  logic mem_hit;
  assign mem_hit = write_q ? mem_write_ready : mem_read_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          write_d = sel_write;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_hit) begin
          if (!write_q) begin
            rdata_d = mem_read_data;
          end
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == C_CNT_LAST)) begin
          // Give up on the BlockRam: flag it and still complete the access
          // so the requester is not stuck; reads return zero.
          terr_d = 1'b1;
          if (!write_q) begin
            rdata_d = '0;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        ptr_d   = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        state_d = ST_RECOVER;
      end

      ST_RECOVER: begin
        // Let any lingering ready level drain so it cannot complete the
        // next access prematurely.
        if (!mem_read_ready && !mem_write_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  // Enables decode straight from registered state, so the asynchronous
  // reset removes them in the same cycle.
  assign mem_read_enable  = (state_q == ST_ISSUE) && !write_q;
  assign mem_write_enable = (state_q == ST_ISSUE) &&  write_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign req_ready        = (state_q == ST_DONE) ? grant_q : '0;
  assign req_rdata        = rdata_q;
  assign grant            = grant_q;
  assign timeout_err      = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Directed self-checking bench for memory_arbiter with a small
//            BlockRam model (registered ready/data, optional stall and
//            lingering ready).
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    grant;
  logic            timeout_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_write_data;
  logic            mem_read_enable;
  logic            mem_write_enable;
  logic            mem_read_ready  = 1'b0;
  logic            mem_write_ready = 1'b0;
  logic [DW-1:0]   mem_read_data   = '0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  memory_arbiter #(
    .NUM_REQ    (N),
    .MADDR_WIDTH(AW),
    .MDATA_WIDTH(DW),
    .TIMEOUT    (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .req_rdata       (req_rdata),
    .grant           (grant),
    .timeout_err     (timeout_err),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_read_ready  (mem_read_ready),
    .mem_write_ready (mem_write_ready),
    .mem_read_data   (mem_read_data)
  );

  // BlockRam model: ready follows the enable one cycle later, may be held
  // off (stall) or kept high for 'linger' extra cycles after the enable
  // drops. Unwritten locations read as {8'h5A, addr[7:0]}.
  logic          stall   = 1'b0;
  logic          mem_clr = 1'b0;
  int            linger  = 0;
  int            rd_lg   = 0;
  int            wr_lg   = 0;
  logic [DW-1:0] mem [256];
  logic [255:0]  written = '0;

  always @(posedge clock) begin
    if (mem_clr) begin
      written <= '0;
    end else if (mem_write_enable) begin
      mem[mem_addr[7:0]]     <= mem_write_data;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_read_data <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : {8'h5A, mem_addr[7:0]};
    if (mem_read_enable && !stall) begin
      mem_read_ready <= 1'b1;
      rd_lg          <= linger;
    end else if (rd_lg > 0) begin
      rd_lg <= rd_lg - 1;
    end else begin
      mem_read_ready <= 1'b0;
    end
    if (mem_write_enable && !stall) begin
      mem_write_ready <= 1'b1;
      wr_lg           <= linger;
    end else if (wr_lg > 0) begin
      wr_lg <= wr_lg - 1;
    end else begin
      mem_write_ready <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[r]          = w;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic test_reset();
    bit got;
    reset     = 1'b0;
    mem_clr   = 1'b1;
    req_valid = 3'b111;
    tick();
    tick();
    mem_clr = 1'b0;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", mem_read_enable); end
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_write_enable); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_write_data !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", mem_write_data); end
    checks++; if (req_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", req_rdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant != 3'b000) break;
    end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL first_grant: got %b expected 001", grant); end
    req_valid = 3'b001;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready[0]) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL first_access_ready: got %b expected 1", got); end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    bit got;
    set_req(1, 1'b1, 16'h0034, 16'h00AB);
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready[1]) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", got); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wr_grant: got %b expected 010", grant); end
    req_valid[1] = 1'b0;
    set_req(1, 1'b0, 16'h0034, 16'h0000);
    tick();
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready[1]) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", got); end
    checks++; if (req_rdata !== 16'h00AB) begin errors++; $display("FAIL rd_data: got %h expected 00ab", req_rdata); end
    req_valid[1] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_rotation();
    int n;
    logic [N-1:0] exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int r = 0; r < N; r++) set_req(r, 1'b0, AW'(16'h0040 + r), '0);
    req_valid = 3'b111;
    n = 0;
    for (int c = 0; c < 200 && n < 9; c++) begin
      tick();
      checks++; if ($countones(grant) > 1) begin errors++; $display("FAIL rot_onehot: got %b expected at most one bit", grant); end
      if (req_ready != '0) begin
        exp = N'(1) << (n % N);
        checks++; if (req_ready !== exp) begin errors++; $display("FAIL rot_order[%0d]: got %b expected %b", n, req_ready, exp); end
        n++;
      end
    end
    checks++; if (n != 9) begin errors++; $display("FAIL rot_count: got %0d expected 9", n); end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int n, last;
    bit en, prev_en;
    logic [7:0] a8;
    logic [DW-1:0] exp;
    linger = 2;
    set_req(2, 1'b0, 16'h0034, '0);
    req_valid[2] = 1'b1;
    n = 0; last = 0; prev_en = 1'b0;
    for (int c = 0; c < 300 && n < 7; c++) begin
      tick();
      en = mem_read_enable | mem_write_enable;
      if (en && !prev_en) begin
        checks++;
        if ((mem_read_ready | mem_write_ready) !== 1'b0) begin
          errors++; $display("FAIL b2b_overlap: got ready=%b%b expected 00 at enable rise", mem_read_ready, mem_write_ready);
        end
      end
      prev_en = en;
      if (req_ready[2]) begin
        a8  = 8'h34 + 8'(n);
        exp = (n == 0) ? 16'h00AB : {8'h5A, a8};
        checks++; if (req_rdata !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", n, req_rdata, exp); end
        if (n > 0) begin
          checks++; if (c - last < 4) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected >=4", n, c - last); end
        end
        last = c;
        n++;
        set_req(2, 1'b0, AW'(16'h0034 + n), '0);
      end
    end
    checks++; if (n != 7) begin errors++; $display("FAIL b2b_count: got %0d expected 7", n); end
    req_valid = '0;
    repeat (6) tick();
    linger = 0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int en_cnt;
    bit got;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre_terr: got %b expected 0", timeout_err); end
    stall = 1'b1;
    set_req(0, 1'b0, 16'h0010, '0);
    req_valid[0] = 1'b1;
    en_cnt = 0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_read_enable) en_cnt++;
      if (req_ready[0]) begin
        got = 1'b1;
        checks++; if (req_rdata !== 16'h0000) begin errors++; $display("FAIL to_rdata: got %h expected 0000", req_rdata); end
        break;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", got); end
    checks++; if (en_cnt != TO) begin errors++; $display("FAIL to_enable_cycles: got %0d expected %0d", en_cnt, TO); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_terr: got %b expected 1", timeout_err); end
    req_valid = '0;
    stall = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    bit seen, got;
    stall = 1'b1;
    set_req(0, 1'b0, 16'h0020, '0);
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mem_read_enable) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_enable_seen: got %b expected 1", seen); end
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if ((mem_read_enable | mem_write_enable) !== 1'b0) begin errors++; $display("FAIL mid_enable_drop: got %b%b expected 00", mem_read_enable, mem_write_enable); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mid_no_ready: got %b expected 000", req_ready); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_terr_clr: got %b expected 0", timeout_err); end
    tick();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mid_no_ready_held: got %b expected 000", req_ready); end
    reset = 1'b1;
    stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant != 3'b000) break;
    end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_regrant: got %b expected 001", grant); end
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready != '0) begin got = 1'b1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", got); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_ready_who: got %b expected 001", req_ready); end
    checks++; if (req_rdata !== 16'h5A20) begin errors++; $display("FAIL mid_rdata: got %h expected 5a20", req_rdata); end
    req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rotation();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
